// File: rtl/lsu_seq_pkg.sv
// Shared types and constants for the LSU request sequencer.
package lsu_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE0  = 2'd1,
        S_ISSUE1  = 2'd2,
        S_WAIT_RD = 2'd3
    } state_t;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    localparam logic W_BYTE = 1'b0;
    localparam logic W_WORD = 1'b1;

    // Part 0 is the request address, part 1 is address + 1 of a split word.
    localparam logic TID_P0 = 1'b0;
    localparam logic TID_P1 = 1'b1;

endpackage

// File: rtl/lsu_rd_align.sv
// Read-return lane steering: turns one LSU return into its masked
// contribution to the 16-bit zero-extended core result.
module lsu_rd_align
    import lsu_seq_pkg::*;
(
    input  logic [15:0] rd_data,
    input  logic        t_id,
    input  logic        width,
    input  logic        split,
    input  logic        lane,
    output logic [15:0] contrib
);

    logic [7:0] sel_byte;

    // Pick the addressed byte, then place it in the result byte it owns.
    always_comb begin
        sel_byte = lane ? rd_data[15:8] : rd_data[7:0];
        contrib  = 16'h0000;
        if (width == W_WORD && !split)
            contrib = rd_data;
        else if (split && t_id == TID_P1)
            contrib = {sel_byte, 8'h00};
        else
            contrib = {8'h00, sel_byte};
    end

endmodule

// File: rtl/lsu_seq_16b.sv
// Core-to-LSU request sequencer: one request at a time, unaligned words
// split into two byte transactions, read returns merged into one result.
module lsu_seq_16b
    import lsu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        a_rst,
    input  logic        cpu_req,
    output logic        cpu_ack,
    input  logic        cpu_cmd,
    input  logic        cpu_width,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_done,
    output logic [15:0] cpu_rdata,
    output logic        cpu_busy,
    output logic [15:0] rq_addr,
    output logic [15:0] rq_data,
    output logic        rq_width,
    output logic        rq_cmd,
    output logic        rq_t_id,
    output logic        rq_wr_addr,
    output logic        rq_start,
    input  logic        rq_ack,
    input  logic        rd_valid,
    input  logic        rd_t_id,
    input  logic [15:0] rd_data
);

    state_t      state;
    logic        cmd_q, width_q, split_q;
    logic        got0, got1;
    logic [15:0] addr_q, wdata_q, acc_q;

    logic        issuing, p0_issued, p1_issued, cap;
    logic        got0_n, got1_n, all_got, lane;
    logic [15:0] addr_p1, contrib, merged;

    assign cpu_ack    = cpu_req & (state == S_IDLE);
    assign cpu_busy   = (state != S_IDLE);
    assign rq_wr_addr = 1'b1;
    assign addr_p1    = addr_q + 16'd1;
    assign issuing    = (state == S_ISSUE0) | (state == S_ISSUE1);

    // Transaction fields decode purely from state and latched request.
    always_comb begin
        rq_start = issuing;
        rq_t_id  = (state == S_ISSUE1) ? TID_P1 : TID_P0;
        rq_cmd   = issuing ? cmd_q : CMD_RD;
        rq_addr  = 16'h0000;
        rq_width = W_BYTE;
        rq_data  = 16'h0000;
        if (state == S_ISSUE0) begin
            rq_addr  = addr_q;
            rq_width = width_q & ~split_q;
            if (cmd_q == CMD_WR)
                rq_data = (width_q & ~split_q) ? wdata_q : {2{wdata_q[7:0]}};
        end else if (state == S_ISSUE1) begin
            rq_addr = addr_p1;
            if (cmd_q == CMD_WR)
                rq_data = {2{wdata_q[15:8]}};
        end
    end

    // A part counts as issued from its own ack cycle onward, so a return
    // in the same cycle as that ack is still accepted.
    always_comb begin
        p0_issued = ((state == S_ISSUE0) & rq_ack) | (state == S_ISSUE1) |
                    (state == S_WAIT_RD);
        p1_issued = split_q & (((state == S_ISSUE1) & rq_ack) | (state == S_WAIT_RD));
        cap       = rd_valid & (cmd_q == CMD_RD) &
                    ((rd_t_id == TID_P0) ? (p0_issued & ~got0) : (p1_issued & ~got1));
        got0_n    = got0 | (cap & (rd_t_id == TID_P0));
        got1_n    = got1 | (cap & (rd_t_id == TID_P1));
        all_got   = got0_n & (~split_q | got1_n);
        // Lane comes from the returning part's own address, not the one
        // currently on rq_addr (part 0 may return while part 1 issues).
        lane      = (rd_t_id == TID_P1) ? addr_p1[0] : addr_q[0];
        merged    = acc_q | (cap ? contrib : 16'h0000);
    end

    lsu_rd_align u_align (
        .rd_data (rd_data),
        .t_id    (rd_t_id),
        .width   (width_q),
        .split   (split_q),
        .lane    (lane),
        .contrib (contrib)
    );

    // Sequencer FSM with registered completion pulse and read result.
    always_ff @(posedge clk) begin
        if (a_rst) begin
            state     <= S_IDLE;
            cmd_q     <= CMD_RD;
            width_q   <= W_BYTE;
            split_q   <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            got0      <= 1'b0;
            got1      <= 1'b0;
            acc_q     <= 16'h0000;
            cpu_done  <= 1'b0;
            cpu_rdata <= 16'h0000;
        end else begin
            cpu_done  <= 1'b0;
            cpu_rdata <= 16'h0000;
            got0      <= got0_n;
            got1      <= got1_n;
            acc_q     <= merged;
            case (state)
                S_IDLE: begin
                    if (cpu_ack) begin
                        cmd_q   <= cpu_cmd;
                        width_q <= cpu_width;
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                        split_q <= cpu_width & cpu_addr[0];
                        got0    <= 1'b0;
                        got1    <= 1'b0;
                        acc_q   <= 16'h0000;
                        state   <= S_ISSUE0;
                    end
                end
                S_ISSUE0: begin
                    if (rq_ack) begin
                        if (split_q) begin
                            state <= S_ISSUE1;
                        end else if (cmd_q == CMD_WR) begin
                            state    <= S_IDLE;
                            cpu_done <= 1'b1;
                        end else if (all_got) begin
                            state     <= S_IDLE;
                            cpu_done  <= 1'b1;
                            cpu_rdata <= merged;
                        end else begin
                            state <= S_WAIT_RD;
                        end
                    end
                end
                S_ISSUE1: begin
                    if (rq_ack) begin
                        if (cmd_q == CMD_WR) begin
                            state    <= S_IDLE;
                            cpu_done <= 1'b1;
                        end else if (all_got) begin
                            state     <= S_IDLE;
                            cpu_done  <= 1'b1;
                            cpu_rdata <= merged;
                        end else begin
                            state <= S_WAIT_RD;
                        end
                    end
                end
                S_WAIT_RD: begin
                    if (all_got) begin
                        state     <= S_IDLE;
                        cpu_done  <= 1'b1;
                        cpu_rdata <= merged;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
